ibwt_top: RTL and testbench

- Inverse Burrows-Wheeler transform engine; the decoder for the forward BWT block.
- Accepts one STRING_LEN-character BWT block serially, one char per cycle.
- Rebuilds the original string by LF-mapping and streams it out serially.
- Sits downstream of the BWT path; the input is the forward block's output_string_char/valid_out stream.

---
 rtl/ibwt_if.sv | 27 ++
 rtl/ibwt_top.sv | 153 +++++++++++++++
 tb/tb_ibwt_top.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/ibwt_if.sv
// ibwt_if: character stream bundle for the inverse BWT engine.
//   valid_in/char_in : BWT characters into the engine
//   ready_in         : engine is accepting a block
//   char_out/valid_out : decoded characters out (no backpressure)
//   busy, err_eos    : engine status
// The slave modport is the engine side; master is the producer/consumer side.
interface ibwt_if #(
  parameter int CHAR_W = 8
);
  logic              valid_in;
  logic [CHAR_W-1:0] char_in;
  logic              ready_in;
  logic [CHAR_W-1:0] char_out;
  logic              valid_out;
  logic              busy;
  logic              err_eos;

  modport master (
    output valid_in, char_in,
    input  ready_in, char_out, valid_out, busy, err_eos
  );

  modport slave (
    input  valid_in, char_in,
    output ready_in, char_out, valid_out, busy, err_eos
  );
endinterface

// File: rtl/ibwt_top.sv
// ibwt_top: inverse Burrows-Wheeler transform engine.
// Loads one STRING_LEN-character BWT block serially, builds the C[] table by
// a prefix sum over the symbol counts, walks the LF mapping backwards from the
// EOS-first rotation, then streams the recovered string out serially.
// Ports:
//   clk      : clock
//   rst      : synchronous, active-high reset
//   bus      : ibwt_if.slave (valid_in, char_in, ready_in, char_out,
//              valid_out, busy, err_eos)
module ibwt_top #(
  parameter int                STRING_LEN = 64,
  parameter int                CHAR_W     = 8,
  parameter logic [CHAR_W-1:0] EOS        = CHAR_W'(8'h24)
) (
  input  logic   clk,
  input  logic   rst,
  ibwt_if.slave  bus
);

  localparam int NSYM = 1 << CHAR_W;
  localparam int CW   = $clog2(STRING_LEN + 1);
  localparam int IW   = $clog2(STRING_LEN);

  typedef logic [CHAR_W-1:0] char_t;
  typedef logic [CW-1:0]     cnt_t;
  typedef logic [IW-1:0]     idx_t;

  localparam idx_t  LAST        = idx_t'(STRING_LEN - 1);
  localparam idx_t  SECOND_LAST = idx_t'(STRING_LEN - 2);
  localparam char_t K_LAST      = '1;

  typedef enum logic [1:0] {S_LOAD, S_PREFIX, S_DECODE, S_SEND} state_t;

  state_t state_q;
  idx_t   ctr_q;
  char_t  k_q;
  cnt_t   acc_q;
  idx_t   row_q;
  char_t  char_out_q;
  logic   valid_out_q;
  logic   busy_q;
  logic   err_eos_q;
  logic   ready_q;

  char_t  l_q    [STRING_LEN];
  cnt_t   rank_q [STRING_LEN];
  char_t  t_q    [STRING_LEN];
  cnt_t   cnt_q  [NSYM];

  char_t  cur_ch;
  idx_t   row_d;
  idx_t   acc_row;
  cnt_t   cnt_in;
  cnt_t   eos_final;
  logic   accept;

  // Single conditional subtract suffices: both operands are <= STRING_LEN.
  function automatic idx_t mod_n(input logic [CW:0] v);
    logic [CW:0] r;
    r = (v >= (CW+1)'(STRING_LEN)) ? v - (CW+1)'(STRING_LEN) : v;
    return idx_t'(r);
  endfunction

  always_comb begin
    cur_ch    = l_q[row_q];
    row_d     = mod_n({1'b0, cnt_q[cur_ch]} + {1'b0, rank_q[row_q]});
    acc_row   = mod_n({1'b0, acc_q});
    cnt_in    = cnt_q[bus.char_in];
    eos_final = cnt_q[EOS] + cnt_t'(bus.char_in == EOS);
    accept    = ready_q && bus.valid_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_LOAD;
      ctr_q       <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      row_q       <= '0;
      char_out_q  <= '0;
      valid_out_q <= 1'b0;
      busy_q      <= 1'b0;
      err_eos_q   <= 1'b0;
      ready_q     <= 1'b1;
      cnt_q       <= '{default: '0};
      l_q         <= '{default: '0};
      rank_q      <= '{default: '0};
      t_q         <= '{default: '0};
    end else begin
      valid_out_q <= 1'b0;
      case (state_q)
        S_LOAD: begin
          // ready is held low for one cycle after the last output character
          ready_q <= 1'b1;
          if (accept) begin
            l_q[ctr_q]          <= bus.char_in;
            rank_q[ctr_q]       <= cnt_in;
            cnt_q[bus.char_in]  <= cnt_in + 1'b1;
            if (ctr_q == LAST) begin
              t_q[LAST] <= EOS;
              ctr_q     <= '0;
              acc_q     <= '0;
              k_q       <= '0;
              err_eos_q <= (eos_final != cnt_t'(1));
              ready_q   <= 1'b0;
              busy_q    <= 1'b1;
              state_q   <= S_PREFIX;
            end else begin
              ctr_q <= ctr_q + 1'b1;
            end
          end
        end
        S_PREFIX: begin
          // cnt[] is rewritten in place from symbol counts to C[]
          cnt_q[k_q] <= acc_q;
          acc_q      <= acc_q + cnt_q[k_q];
          if (k_q == EOS) row_q <= acc_row;
          k_q <= k_q + 1'b1;
          if (k_q == K_LAST) begin
            ctr_q   <= SECOND_LAST;
            state_q <= S_DECODE;
          end
        end
        S_DECODE: begin
          t_q[ctr_q] <= cur_ch;
          row_q      <= row_d;
          if (ctr_q == '0) state_q <= S_SEND;
          else             ctr_q   <= ctr_q - 1'b1;
        end
        S_SEND: begin
          char_out_q  <= t_q[ctr_q];
          valid_out_q <= 1'b1;
          if (ctr_q == LAST) begin
            ctr_q   <= '0;
            cnt_q   <= '{default: '0};
            busy_q  <= 1'b0;
            state_q <= S_LOAD;
          end else begin
            ctr_q <= ctr_q + 1'b1;
          end
        end
        default: state_q <= S_LOAD;
      endcase
    end
  end

  assign bus.ready_in  = ready_q;
  assign bus.char_out  = char_out_q;
  assign bus.valid_out = valid_out_q;
  assign bus.busy      = busy_q;
  assign bus.err_eos   = err_eos_q;

endmodule

// File: tb/tb_ibwt_top.sv
// tb_ibwt_top: self-checking bench for ibwt_top.
// DUT A: STRING_LEN=7, EOS=8'h24. DUT B: STRING_LEN=4, EOS=8'h00.
// Random cases build the BWT of a random string by sorting its rotations and
// expect the original string back.
module tb_ibwt_top;
  logic clk = 1'b0;
  logic rst;
  int   edge_n = 0;
  int   nvec = 0;
  int   nerr = 0;

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  ibwt_if #(.CHAR_W(8)) a_if ();
  ibwt_if #(.CHAR_W(8)) b_if ();

  ibwt_top #(.STRING_LEN(7), .CHAR_W(8), .EOS(8'h24)) dut_a (
    .clk(clk), .rst(rst), .bus(a_if.slave)
  );
  ibwt_top #(.STRING_LEN(4), .CHAR_W(8), .EOS(8'h00)) dut_b (
    .clk(clk), .rst(rst), .bus(b_if.slave)
  );

  typedef struct {
    logic [55:0] l_s;
    logic [55:0] exp_s;
    bit          err;
    bit          chk_data;
    int          gap;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  function automatic logic [7:0] byte_at(input logic [55:0] s, input int i);
    return s[8*(6-i) +: 8];
  endfunction

  function automatic bit rot_less(input logic [55:0] t, input int a, input int b);
    for (int k = 0; k < 7; k++) begin
      logic [7:0] ca, cb;
      ca = byte_at(t, (a + k) % 7);
      cb = byte_at(t, (b + k) % 7);
      if (ca != cb) return ca < cb;
    end
    return 1'b0;
  endfunction

  // Forward BWT: last column of the sorted rotation table.
  function automatic logic [55:0] bwt7(input logic [55:0] t);
    int idx[7];
    int tmp;
    logic [55:0] l;
    for (int i = 0; i < 7; i++) idx[i] = i;
    for (int i = 1; i < 7; i++)
      for (int j = i; j > 0 && rot_less(t, idx[j], idx[j-1]); j--) begin
        tmp = idx[j]; idx[j] = idx[j-1]; idx[j-1] = tmp;
      end
    l = '0;
    for (int r = 0; r < 7; r++) l[8*(6-r) +: 8] = byte_at(t, (idx[r] + 6) % 7);
    return l;
  endfunction

  task automatic send_a(input logic [55:0] s, input int gap, output int e0);
    for (int t = 0; t < 600 && !a_if.ready_in; t++) tick();
    chk("ready_before_send", a_if.ready_in, 1);
    for (int i = 0; i < 7; i++) begin
      if (gap != 0 && i != 0) begin
        a_if.valid_in = 1'b0;
        a_if.char_in  = 8'($urandom);
        tick();
      end
      a_if.valid_in = 1'b1;
      a_if.char_in  = byte_at(s, i);
      tick();
    end
    e0 = edge_n;
    a_if.valid_in = 1'b0;
  endtask

  task automatic collect_a(input logic [55:0] exp, input bit chk_data,
                           input bit exp_err, input int e0);
    int first;
    chk("err_eos", a_if.err_eos, exp_err);
    first = -1;
    for (int t = 0; t < 400 && first < 0; t++) begin
      tick();
      if (edge_n == e0 + 1) chk("busy_after_load", a_if.busy, 1);
      if (a_if.valid_out) first = edge_n;
    end
    if (first < 0) begin
      chk("valid_out_timeout", 0, 1);
    end else begin
      chk("latency", first - e0, 263);
      for (int k = 0; k < 7; k++) begin
        if (k > 0) tick();
        chk("valid_out_run", a_if.valid_out, 1);
        if (chk_data) chk("char_out", a_if.char_out, byte_at(exp, k));
      end
      chk("ready_low_last_out", a_if.ready_in, 0);
      tick();
      chk("valid_out_end", a_if.valid_out, 0);
      chk("ready_back", a_if.ready_in, 1);
      chk("busy_end", a_if.busy, 0);
    end
  endtask

  initial begin
    int e0, first, seen;
    logic [55:0] t_s, l_s, junk;
    logic [31:0] bin;

    a_if.valid_in = 1'b0; a_if.char_in = '0;
    b_if.valid_in = 1'b0; b_if.char_in = '0;
    rst = 1'b1;
    tick(); tick();
    chk("rst_ready", a_if.ready_in, 1);
    chk("rst_valid", a_if.valid_out, 0);
    chk("rst_busy", a_if.busy, 0);
    chk("rst_err", a_if.err_eos, 0);
    chk("rst_char", a_if.char_out, 0);
    chk("rst_b_valid", b_if.valid_out, 0);
    rst = 1'b0;
    tick();

    vecs[0] = '{l_s: "annb$aa", exp_s: "banana$", err: 1'b0, chk_data: 1'b1, gap: 0};
    vecs[1] = '{l_s: "annb$aa", exp_s: "banana$", err: 1'b0, chk_data: 1'b1, gap: 1};
    vecs[2] = '{l_s: "aaaaaa$", exp_s: "aaaaaa$", err: 1'b0, chk_data: 1'b1, gap: 0};
    vecs[3] = '{l_s: "annbxaa", exp_s: 56'h0,     err: 1'b1, chk_data: 1'b0, gap: 0};
    for (int v = 0; v < 4; v++) begin
      send_a(vecs[v].l_s, vecs[v].gap, e0);
      collect_a(vecs[v].exp_s, vecs[v].chk_data, vecs[v].err, e0);
    end

    for (int n = 0; n < 6; n++) begin
      t_s = '0;
      for (int i = 0; i < 6; i++) begin
        logic [7:0] c;
        c = 8'($urandom_range(0, 255));
        if (c == 8'h24) c = 8'h25;
        t_s[8*(6-i) +: 8] = c;
      end
      t_s[7:0] = 8'h24;
      l_s = bwt7(t_s);
      send_a(l_s, n % 2, e0);
      collect_a(t_s, 1'b1, 1'b0, e0);
    end

    // DUT B: EOS=00 is the smallest symbol
    bin = 32'h61616100;
    chk("b_ready", b_if.ready_in, 1);
    for (int i = 0; i < 4; i++) begin
      b_if.valid_in = 1'b1;
      b_if.char_in  = bin[8*(3-i) +: 8];
      tick();
    end
    e0 = edge_n;
    b_if.valid_in = 1'b0;
    chk("b_err_eos", b_if.err_eos, 0);
    first = -1;
    for (int t = 0; t < 400 && first < 0; t++) begin
      tick();
      if (b_if.valid_out) first = edge_n;
    end
    if (first < 0) begin
      chk("b_valid_timeout", 0, 1);
    end else begin
      chk("b_latency", first - e0, 260);
      for (int k = 0; k < 4; k++) begin
        if (k > 0) tick();
        chk("b_valid_run", b_if.valid_out, 1);
        chk("b_char_out", b_if.char_out, bin[8*(3-k) +: 8]);
      end
      tick();
      chk("b_valid_end", b_if.valid_out, 0);
      chk("b_ready_back", b_if.ready_in, 1);
    end

    // Reset in the middle of the decode walk
    l_s = "annb$aa";
    send_a(l_s, 0, e0);
    for (int t = 0; t < 400 && edge_n < e0 + 259; t++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", a_if.ready_in, 1);
    chk("midrst_valid", a_if.valid_out, 0);
    chk("midrst_busy", a_if.busy, 0);
    seen = 0;
    for (int t = 0; t < 300; t++) begin
      tick();
      if (a_if.valid_out) seen++;
    end
    chk("midrst_no_output", seen, 0);
    send_a(l_s, 0, e0);
    collect_a("banana$", 1'b1, 1'b0, e0);

    // Second block offered while busy is ignored, then resent
    send_a(l_s, 0, e0);
    junk = "aaaaaa$";
    for (int i = 0; i < 7; i++) begin
      a_if.valid_in = 1'b1;
      a_if.char_in  = byte_at(junk, i);
      tick();
      chk("ready_low_busy", a_if.ready_in, 0);
    end
    a_if.valid_in = 1'b0;
    collect_a("banana$", 1'b1, 1'b0, e0);
    send_a(junk, 0, e0);
    collect_a("aaaaaa$", 1'b1, 1'b0, e0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
